traffic_ctrl: RTL and testbench

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/phase_timer.sv | 39 +++
 rtl/traffic_ctrl.sv | 136 +++++++++++++
 tb/tb_traffic_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared state enumeration and lamp encoding for the traffic light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_RED    = 3'd2,
    S_WALK   = 3'd3,
    S_FLASH  = 3'd4
  } state_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
    logic walk;
    logic flash;
    logic dont;
  } lamps_t;

  localparam lamps_t LAMPS_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1, walk: 1'b0, flash: 1'b0, dont: 1'b1};
  localparam lamps_t LAMPS_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0, walk: 1'b0, flash: 1'b0, dont: 1'b1};
  localparam lamps_t LAMPS_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0, walk: 1'b0, flash: 1'b0, dont: 1'b1};
  localparam lamps_t LAMPS_WALK   = '{red: 1'b1, yellow: 1'b0, green: 1'b0, walk: 1'b1, flash: 1'b0, dont: 1'b0};
  localparam lamps_t LAMPS_FLASH  = '{red: 1'b1, yellow: 1'b0, green: 1'b0, walk: 1'b0, flash: 1'b1, dont: 1'b0};

  // Unknown encodings fall back to the all-stop lamp set.
  function automatic lamps_t lamp_encode(input state_e s);
    lamps_t l;
    case (s)
      S_GREEN:  l = LAMPS_GREEN;
      S_YELLOW: l = LAMPS_YELLOW;
      S_RED:    l = LAMPS_RED;
      S_WALK:   l = LAMPS_WALK;
      S_FLASH:  l = LAMPS_FLASH;
      default:  l = LAMPS_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled phase counter; expire fires on the tick that completes 'limit' ticks.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    expire = tick && (cnt_q == (limit - CNT_W'(1)));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Traffic light controller with optional pedestrian phases (macro TRAFFIC_CTRL_PED_EN).
// All lamp outputs and ped_pending are registered.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 4,
  parameter int YELLOW_TICKS = 3,
  parameter int RED_TICKS    = 10,
  parameter int WALK_TICKS   = 5,
  parameter int FLASH_TICKS  = 3,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic ped_req,
  output logic red,
  output logic yellow,
  output logic green,
  output logic walk,
  output logic flash,
  output logic dont,
  output logic ped_pending
);

  localparam int MAX_TICKS = (1 << CNT_W) - 1;

  if (GREEN_TICKS < 1 || GREEN_TICKS > MAX_TICKS) begin : g_bad_green
    $error("traffic_ctrl: GREEN_TICKS out of range 1..2^CNT_W-1");
  end
  if (YELLOW_TICKS < 1 || YELLOW_TICKS > MAX_TICKS) begin : g_bad_yellow
    $error("traffic_ctrl: YELLOW_TICKS out of range 1..2^CNT_W-1");
  end
  if (RED_TICKS < 1 || RED_TICKS > MAX_TICKS) begin : g_bad_red
    $error("traffic_ctrl: RED_TICKS out of range 1..2^CNT_W-1");
  end
  if (WALK_TICKS < 1 || WALK_TICKS > MAX_TICKS) begin : g_bad_walk
    $error("traffic_ctrl: WALK_TICKS out of range 1..2^CNT_W-1");
  end
  if (FLASH_TICKS < 1 || FLASH_TICKS > MAX_TICKS) begin : g_bad_flash
    $error("traffic_ctrl: FLASH_TICKS out of range 1..2^CNT_W-1");
  end

  state_e           state_q, state_d;
  logic             ped_pending_q, ped_pending_d;
  lamps_t           lamps_q, lamps_d;
  logic [CNT_W-1:0] limit_s;
  logic             expire_s;

  always_comb begin
    case (state_q)
      S_GREEN:  limit_s = CNT_W'(GREEN_TICKS);
      S_YELLOW: limit_s = CNT_W'(YELLOW_TICKS);
      S_RED:    limit_s = CNT_W'(RED_TICKS);
      S_WALK:   limit_s = CNT_W'(WALK_TICKS);
      S_FLASH:  limit_s = CNT_W'(FLASH_TICKS);
      default:  limit_s = CNT_W'(RED_TICKS);
    endcase
  end

  // Every expiry is a state change, so expiry doubles as the counter clear.
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (expire_s),
    .tick   (tick),
    .limit  (limit_s),
    .expire (expire_s)
  );

  always_comb begin
    state_d = state_q;
    if (expire_s) begin
      case (state_q)
        S_GREEN:  state_d = S_YELLOW;
        S_YELLOW: state_d = S_RED;
`ifdef TRAFFIC_CTRL_PED_EN
        S_RED:    state_d = ped_pending_q ? S_WALK : S_GREEN;
        S_WALK:   state_d = S_FLASH;
        S_FLASH:  state_d = S_GREEN;
`else
        S_RED:    state_d = S_GREEN;
`endif
        default:  state_d = S_RED;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Entering WALK serves the request and wins over a simultaneous press.
  always_comb begin
    ped_pending_d = ped_pending_q;
`ifdef TRAFFIC_CTRL_PED_EN
    if (state_d == S_WALK && state_q != S_WALK) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q == S_GREEN || state_q == S_YELLOW || state_q == S_RED)) begin
      ped_pending_d = 1'b1;
    end else begin
      ped_pending_d = ped_pending_q;
    end
`else
    ped_pending_d = 1'b0;
`endif
  end

  always_comb begin
    lamps_d = lamp_encode(state_d);
`ifndef TRAFFIC_CTRL_PED_EN
    lamps_d.walk  = 1'b0;
    lamps_d.flash = 1'b0;
    lamps_d.dont  = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RED;
      ped_pending_q <= 1'b0;
      lamps_q       <= LAMPS_RED;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      lamps_q       <= lamps_d;
    end
  end

  assign red         = lamps_q.red;
  assign yellow      = lamps_q.yellow;
  assign green       = lamps_q.green;
  assign walk        = lamps_q.walk;
  assign flash       = lamps_q.flash;
  assign dont        = lamps_q.dont;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed self-checking bench for traffic_ctrl (default parameters).
module tb_traffic_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic ped_req = 1'b0;
  logic red, yellow, green, walk, flash, dont, ped_pending;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] L_RED   = 6'b100001;
  localparam logic [5:0] L_YEL   = 6'b010001;
  localparam logic [5:0] L_GRN   = 6'b001001;
  localparam logic [5:0] L_WALK  = 6'b100100;
  localparam logic [5:0] L_FLASH = 6'b100010;

  logic [5:0] lv;
  assign lv = {red, yellow, green, walk, flash, dont};

  traffic_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .ped_req     (ped_req),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .walk        (walk),
    .flash       (flash),
    .dont        (dont),
    .ped_pending (ped_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick = 1'b1;
    ped_req = 1'b1;
    do_reset();
    checks++;
    if (lv !== L_RED) begin
      errors++;
      $display("FAIL reset_lamps got %b want %b", lv, L_RED);
    end
    checks++;
    if (ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending got %b want 0", ped_pending);
    end
    ped_req = 1'b0;
  endtask

  // Red 10, green 4, yellow 3 with tick every cycle; ped_req held high.
  task automatic test_cycle_no_ped();
    logic [5:0] exp;
    tick = 1'b1;
    ped_req = 1'b1;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if ((c % 17) < 10) exp = L_RED;
      else if ((c % 17) < 14) exp = L_GRN;
      else exp = L_YEL;
      checks++;
      if (lv !== exp) begin
        errors++;
        $display("FAIL cycle_lamps c=%0d got %b want %b", c, lv, exp);
      end
      checks++;
      if (ped_pending !== 1'b0) begin
        errors++;
        $display("FAIL cycle_pending c=%0d got %b want 0", c, ped_pending);
      end
      step();
    end
    ped_req = 1'b0;
  endtask

  // tick on every 4th cycle stretches each phase to 4*N cycles.
  task automatic test_slow_tick();
    logic [5:0] exp;
    tick = 1'b0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      tick = ((c % 4) == 3);
      if ((c % 68) < 40) exp = L_RED;
      else if ((c % 68) < 56) exp = L_GRN;
      else exp = L_YEL;
      checks++;
      if (lv !== exp) begin
        errors++;
        $display("FAIL slow_tick c=%0d got %b want %b", c, lv, exp);
      end
      step();
    end
    tick = 1'b0;
  endtask

  // Reset in mid-yellow with a pending request, then a full red phase.
  task automatic test_reset_mid();
    logic [5:0] exp;
    tick = 1'b1;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      ped_req = (c == 11);
      step();
    end
    ped_req = 1'b0;
    checks++;
    if (lv !== L_YEL) begin
      errors++;
      $display("FAIL mid_yellow got %b want %b", lv, L_YEL);
    end
`ifdef TRAFFIC_CTRL_PED_EN
    checks++;
    if (ped_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending got %b want 1", ped_pending);
    end
`endif
    ped_req = 1'b1;
    do_reset();
    ped_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      exp = (c < 10) ? L_RED : L_GRN;
      checks++;
      if (lv !== exp) begin
        errors++;
        $display("FAIL after_reset c=%0d got %b want %b", c, lv, exp);
      end
      checks++;
      if (ped_pending !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_pending c=%0d got %b want 0", c, ped_pending);
      end
      step();
    end
  endtask

`ifdef TRAFFIC_CTRL_PED_EN
  // Pulse at cycle 12 (green): walk/flash inserted after the next red.
  task automatic test_ped_pulse();
    logic [5:0] exp;
    logic       exp_p;
    tick = 1'b1;
    do_reset();
    for (int c = 0; c < 46; c++) begin
      ped_req = (c == 12);
      if (c < 10 || (c >= 17 && c < 27) || c >= 42) exp = L_RED;
      else if ((c >= 10 && c < 14) || (c >= 35 && c < 39)) exp = L_GRN;
      else if ((c >= 14 && c < 17) || (c >= 39 && c < 42)) exp = L_YEL;
      else if (c < 32) exp = L_WALK;
      else exp = L_FLASH;
      exp_p = (c >= 13 && c < 27);
      checks++;
      if (lv !== exp) begin
        errors++;
        $display("FAIL ped_pulse c=%0d got %b want %b", c, lv, exp);
      end
      checks++;
      if (ped_pending !== exp_p) begin
        errors++;
        $display("FAIL ped_pulse_pending c=%0d got %b want %b", c, ped_pending, exp_p);
      end
      step();
    end
    ped_req = 1'b0;
  endtask

  // Held button: ignored in walk/flash, re-latched in green; one-hot every cycle.
  task automatic test_ped_hold();
    logic [5:0] exp;
    logic       exp_p;
    tick = 1'b1;
    ped_req = 1'b1;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c < 10 || (c >= 25 && c < 35)) exp = L_RED;
      else if (c < 15 || c >= 35) exp = L_WALK;
      else if (c < 18) exp = L_FLASH;
      else if (c < 22) exp = L_GRN;
      else exp = L_YEL;
      exp_p = (c >= 1 && c < 10) || (c >= 19 && c < 35);
      checks++;
      if (lv !== exp) begin
        errors++;
        $display("FAIL ped_hold c=%0d got %b want %b", c, lv, exp);
      end
      checks++;
      if (ped_pending !== exp_p) begin
        errors++;
        $display("FAIL ped_hold_pending c=%0d got %b want %b", c, ped_pending, exp_p);
      end
      checks++;
      if ((32'(red) + 32'(yellow) + 32'(green)) != 1 || (32'(walk) + 32'(flash) + 32'(dont)) != 1) begin
        errors++;
        $display("FAIL one_hot c=%0d got %b want one vehicle and one ped lamp", c, lv);
      end
      step();
    end
    ped_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef TRAFFIC_CTRL_PED_EN
    test_ped_pulse();
    test_ped_hold();
`else
    test_cycle_no_ped();
`endif
    test_slow_tick();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
